// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the core operand path and mul_div_unit.
// The master is the core side; the slave is the iterative unit.
interface mul_div_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [4:0]      rd_in;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, funct3, rd_in, rs1_data, rs2_data,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, funct3, rd_in, rs1_data, rs2_data,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// Optional macro MDU_EARLY_OUT_EN lets trivial operations skip the iteration phase.
module mul_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  mul_div_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [XLEN-1:0]   ONE_X   = XLEN'(1);
  localparam logic [2*XLEN-1:0] ONE_2X  = (2*XLEN)'(1);
  localparam logic [CNT_W-1:0]  ONE_CNT = CNT_W'(1);
  localparam logic [CNT_W-1:0]  LAST    = CNT_W'(XLEN - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic              negRes_q, negRes_d;
  logic              divZero_q, divZero_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rdOut_q, rdOut_d;
  logic              done_q, done_d;

  logic            isDivIn;
  logic            signedA;
  logic            signedB;
  logic            negA;
  logic            negB;
  logic [XLEN-1:0] magA;
  logic [XLEN-1:0] magB;
  logic            negResIn;
  logic            divZeroIn;

  // funct3[2] separates divide from multiply; funct3[0] marks the unsigned divide forms
  assign isDivIn   = bus.funct3[2];
  assign signedA   = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
  assign signedB   = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
  assign negA      = signedA & bus.rs1_data[XLEN-1];
  assign negB      = signedB & bus.rs2_data[XLEN-1];
  assign magA      = negA ? (~bus.rs1_data + ONE_X) : bus.rs1_data;
  assign magB      = negB ? (~bus.rs2_data + ONE_X) : bus.rs2_data;
  assign negResIn  = (bus.funct3[2] & bus.funct3[1]) ? negA : (negA ^ negB);
  assign divZeroIn = (bus.rs2_data == '0);

`ifdef MDU_EARLY_OUT_EN
  logic earlyMul;
  logic earlyOvf;
  assign earlyMul = ~isDivIn & ((bus.rs1_data == '0) | (bus.rs2_data == '0));
  assign earlyOvf = isDivIn & ~bus.funct3[0]
                  & (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                  & (bus.rs2_data == '1);
`endif

  logic [XLEN:0]     mulSum;
  logic [2*XLEN-1:0] mulStep;
  logic [XLEN:0]     divShifted;
  logic [XLEN:0]     divDiff;
  logic [2*XLEN-1:0] divStep;

  // Multiplier sits in the low half and drains out of bit 0 as the product fills in from the top
  assign mulSum  = acc_q[0] ? ({1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, a_q})
                            : {1'b0, acc_q[2*XLEN-1:XLEN]};
  assign mulStep = {mulSum, acc_q[XLEN-1:1]};

  // Remainder in the high half, dividend shifting out of the low half as quotient bits shift in
  assign divShifted = acc_q[2*XLEN-1:XLEN-1];
  assign divDiff    = divShifted - {1'b0, b_q};
  assign divStep    = (divShifted >= {1'b0, b_q})
                    ? {divDiff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                    : {divShifted[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

  logic [2*XLEN-1:0] prodFixed;
  logic [XLEN-1:0]   quoFixed;
  logic [XLEN-1:0]   remFixed;
  logic [XLEN-1:0]   fixResult;

  // Divide by zero keeps an all-ones quotient regardless of the dividend sign
  assign prodFixed = negRes_q ? (~acc_q + ONE_2X) : acc_q;
  assign quoFixed  = divZero_q ? '1
                   : (negRes_q ? (~acc_q[XLEN-1:0] + ONE_X) : acc_q[XLEN-1:0]);
  assign remFixed  = negRes_q ? (~acc_q[2*XLEN-1:XLEN] + ONE_X) : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    fixResult = '0;
    case (op_q)
      3'b000:          fixResult = prodFixed[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:          fixResult = prodFixed[2*XLEN-1:XLEN];
      3'b100, 3'b101:  fixResult = quoFixed;
      default:         fixResult = remFixed;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    a_d       = a_q;
    b_d       = b_q;
    negRes_d  = negRes_q;
    divZero_d = divZero_q;
    acc_d     = acc_q;
    result_d  = result_q;
    rdOut_d   = rdOut_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d      = bus.funct3;
          rd_d      = bus.rd_in;
          a_d       = magA;
          b_d       = magB;
          negRes_d  = negResIn;
          divZero_d = isDivIn & divZeroIn;
          cnt_d     = '0;
          acc_d     = isDivIn ? {{XLEN{1'b0}}, magA} : {{XLEN{1'b0}}, magB};
          state_d   = BUSY;
`ifdef MDU_EARLY_OUT_EN
          // Pre-load the accumulator with what the full iteration would have produced
          if (earlyMul) begin
            acc_d   = '0;
            state_d = FIX;
          end else if (isDivIn & divZeroIn) begin
            acc_d   = {magA, {XLEN{1'b1}}};
            state_d = FIX;
          end else if (earlyOvf) begin
            acc_d   = {{XLEN{1'b0}}, magA};
            state_d = FIX;
          end
`endif
        end
      end
      BUSY: begin
        cnt_d = cnt_q + ONE_CNT;
        acc_d = op_q[2] ? divStep : mulStep;
        if (cnt_q == LAST) begin
          state_d = FIX;
        end
      end
      FIX: begin
        result_d = fixResult;
        rdOut_d  = rd_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      negRes_q  <= 1'b0;
      divZero_q <= 1'b0;
      acc_q     <= '0;
      result_q  <= '0;
      rdOut_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      a_q       <= a_d;
      b_q       <= b_d;
      negRes_q  <= negRes_d;
      divZero_q <= divZero_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      rdOut_q   <= rdOut_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.rd_out = rdOut_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed RV32M vectors, handshake corners and mid-op reset.
module tb_mul_div_unit;

`ifdef MDU_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cycle;
  int   assertCount;
  int   failCount;
  exp_t sbq[$];
  exp_t monItem;
  logic prevDone;

  mul_div_unit_if #(.XLEN(32)) bus();

  mul_div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Issued at a negedge; start is sampled at the following posedge
  task automatic applyStimulus(input logic [2:0] f, input logic [4:0] rd,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expRes, input bit early,
                               input bit expectDone);
    exp_t e;
    e.res = expRes;
    e.rd  = rd;
    e.cyc = cycle + 1 + ((early && EARLY) ? 1 : 33);
    if (expectDone) sbq.push_back(e);
    bus.start    = 1'b1;
    bus.funct3   = f;
    bus.rd_in    = rd;
    bus.rs1_data = a;
    bus.rs2_data = b;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("busyAfterAccept", {31'b0, bus.busy}, 32'd1);
  endtask

  task automatic waitDone();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL doneTimeout: got no done expected done within 60 cycles");
    end
  endtask

  // Monitor: pops the oldest expectation whenever the unit presents a result
  initial prevDone = 1'b0;
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      checkOutput("doneWidth", {31'b0, prevDone}, 32'd0);
      checkOutput("busyAtDone", {31'b0, bus.busy}, 32'd0);
      if (sbq.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpectedDone: got done with result 0x%08h expected no done", bus.result);
      end else begin
        monItem = sbq.pop_front();
        checkOutput("result", bus.result, monItem.res);
        checkOutput("rdOut", {27'b0, bus.rd_out}, {27'b0, monItem.rd});
        checkOutput("doneCycle", cycle, monItem.cyc);
      end
    end
    prevDone = rst_n & bus.done;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    assertCount  = 0;
    failCount    = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.funct3   = 3'b000;
    bus.rd_in    = 5'd0;
    bus.rs1_data = 32'd0;
    bus.rs2_data = 32'd0;
    repeat (3) @(negedge clk);
    checkOutput("resetBusy", {31'b0, bus.busy}, 32'd0);
    checkOutput("resetDone", {31'b0, bus.done}, 32'd0);
    checkOutput("resetResult", bus.result, 32'd0);
    checkOutput("resetRdOut", {27'b0, bus.rd_out}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(3'b000, 5'd5, 32'h0000000C, 32'h00000007, 32'h00000054, 1'b0, 1'b1);
    waitDone(); @(negedge clk);

    applyStimulus(3'b001, 5'd1, 32'hFFFFFFFB, 32'h0000000C, 32'hFFFFFFFF, 1'b0, 1'b1);
    waitDone(); @(negedge clk);
    applyStimulus(3'b010, 5'd2, 32'hFFFFFFFB, 32'h0000000C, 32'hFFFFFFFF, 1'b0, 1'b1);
    waitDone(); @(negedge clk);
    applyStimulus(3'b011, 5'd3, 32'hFFFFFFFB, 32'h0000000C, 32'h0000000B, 1'b0, 1'b1);
    waitDone(); @(negedge clk);
    applyStimulus(3'b000, 5'd4, 32'hFFFFFFFB, 32'h0000000C, 32'hFFFFFFC4, 1'b0, 1'b1);
    waitDone(); @(negedge clk);

    applyStimulus(3'b100, 5'd6, 32'hFFFFFFF7, 32'h00000002, 32'hFFFFFFFC, 1'b0, 1'b1);
    waitDone(); @(negedge clk);
    applyStimulus(3'b110, 5'd7, 32'hFFFFFFF7, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b1);
    waitDone(); @(negedge clk);
    applyStimulus(3'b101, 5'd8, 32'hFFFFFFF7, 32'h00000002, 32'h7FFFFFFB, 1'b0, 1'b1);
    waitDone(); @(negedge clk);
    applyStimulus(3'b111, 5'd9, 32'hFFFFFFF7, 32'h00000002, 32'h00000001, 1'b0, 1'b1);
    waitDone(); @(negedge clk);

    // Division corners and zero multiplies
    applyStimulus(3'b101, 5'd10, 32'h0A050102, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b1);
    waitDone(); @(negedge clk);
    applyStimulus(3'b111, 5'd11, 32'h0A050102, 32'h00000000, 32'h0A050102, 1'b1, 1'b1);
    waitDone(); @(negedge clk);
    applyStimulus(3'b100, 5'd12, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b1);
    waitDone(); @(negedge clk);
    applyStimulus(3'b110, 5'd13, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1);
    waitDone(); @(negedge clk);
    applyStimulus(3'b100, 5'd14, 32'hFFFFFFF7, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b1);
    waitDone(); @(negedge clk);
    applyStimulus(3'b110, 5'd15, 32'hFFFFFFF7, 32'h00000000, 32'hFFFFFFF7, 1'b1, 1'b1);
    waitDone(); @(negedge clk);
    applyStimulus(3'b001, 5'd16, 32'h00000000, 32'h12345678, 32'h00000000, 1'b1, 1'b1);
    waitDone(); @(negedge clk);

    // A second start while busy must be dropped
    applyStimulus(3'b000, 5'd5, 32'h0000000C, 32'h00000007, 32'h00000054, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    bus.start    = 1'b1;
    bus.funct3   = 3'b101;
    bus.rd_in    = 5'd9;
    bus.rs1_data = 32'd100;
    bus.rs2_data = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(); @(negedge clk);

    // Back-to-back: the next start lands in the done cycle
    applyStimulus(3'b011, 5'd3, 32'hFFFFFFFB, 32'h0000000C, 32'h0000000B, 1'b0, 1'b1);
    waitDone();
    applyStimulus(3'b100, 5'd4, 32'hFFFFFFF7, 32'h00000002, 32'hFFFFFFFC, 1'b0, 1'b1);
    checkOutput("heldResult", bus.result, 32'h0000000B);
    checkOutput("heldRdOut", {27'b0, bus.rd_out}, 32'd3);
    waitDone(); @(negedge clk);

    // Asynchronous reset in the middle of a divide
    applyStimulus(3'b100, 5'd17, 32'h00000064, 32'h00000007, 32'h0000000E, 1'b0, 1'b0);
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midResetBusy", {31'b0, bus.busy}, 32'd0);
    checkOutput("midResetDone", {31'b0, bus.done}, 32'd0);
    checkOutput("midResetResult", bus.result, 32'd0);
    checkOutput("midResetRdOut", {27'b0, bus.rd_out}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    applyStimulus(3'b000, 5'd18, 32'h00000003, 32'h00000004, 32'h0000000C, 1'b0, 1'b1);
    waitDone(); @(negedge clk);

    repeat (3) @(negedge clk);
    checkOutput("scoreboardEmpty", sbq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide unit.
- Sits between the register file read ports and the write-back path.
- Consumes rs1/rs2 read data, runs a 32-iteration shift-add multiply or restoring divide, and returns a result plus destination register index for a negedge register-file write.
- The core stalls on `busy`.

Parameters:
- XLEN, 32: operand/result width. Must be even and ≥8; all test values assume 32.
- CNT_W, 6: iteration counter width. Must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rd_in  in  5  destination register index, captured with operands
- rs1_data  in  XLEN  operand A (multiplicand / dividend)
- rs2_data  in  XLEN  operand B (multiplier / divisor)
- busy  out  1  high from accepting edge until the edge that raises done
- done  out  1  one-cycle pulse; result/rd_out valid; doubles as write_enable
- result  out  XLEN  registered result; held until the next accepted start
- rd_out  out  5  registered copy of rd_in; held with result

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, result=0, rd_out=0, counter=0.
  - Applies immediately, including mid-operation; the in-flight op is discarded and no done is produced.
- State IDLE:
  - start=1 at edge N latches funct3, rd_in, |A|, |B| and the sign flags per op; counter=0; state→BUSY; busy=1.
  - start=0 → stay in IDLE.
- Operand sign rules:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - Signed operands are converted to magnitudes; result sign = sign(A) XOR sign(B) for products/quotients, sign(A) for remainders.
- State BUSY: one iteration per edge, counter+1.
  - Multiply: 2·XLEN-bit accumulator; add shifted multiplicand when the multiplier LSB is 1.
  - Divide: restoring; shift remainder left, trial-subtract divisor, set quotient bit if non-negative.
  - After XLEN iterations (edge N+XLEN) → state FIX.
- State FIX (edge N+XLEN+1):
  - Apply two's-complement sign correction.
  - Select output: MUL = low XLEN bits; MULH/MULHSU/MULHU = high XLEN bits; DIV/DIVU = quotient; REM/REMU = remainder.
  - Register result and rd_out; done=1; busy=0; state→IDLE.
- Latency: start accepted at edge N → done high for exactly the cycle after edge N+33 (XLEN=32). done drops at the next edge.
- start while busy=1 is ignored: no queuing, latched operands unaffected.
- start asserted in the cycle where done=1 is accepted (back-to-back). result and rd_out then hold their previous values until the new FIX.
- Divide by zero (B=0):
  - DIV/DIVU quotient = all ones (0xFFFFFFFF).
  - REM/REMU remainder = A (original, unsigned view).
  - Full latency applies.
- Signed overflow (DIV/REM, A=0x80000000, B=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- Results are truncated modulo 2^XLEN; no exceptions or flags.

Optional Feature:
- Macro MDU_EARLY_OUT_EN.
- Defined: in IDLE, on an accepted start, divide-by-zero, signed-overflow, or either multiply operand = 0 skip BUSY and go directly to FIX. done is then high the cycle after edge N+1. Results are identical to the full path.
- Undefined: every op takes the full XLEN+1 cycles; latency is constant and data-independent.

Test Plan:
- MUL: rs1=0x0000000C, rs2=0x00000007, rd_in=5, start at edge N → done=1 after edge N+33 for one cycle, result=0x00000054, rd_out=5; busy=1 from edge N to edge N+33.
- MULH/MULHSU/MULHU: rs1=0xFFFFFFFB, rs2=0x0000000C → MULH 0xFFFFFFFF, MULHSU 0xFFFFFFFF, MULHU 0x0000000B, MUL 0xFFFFFFC4.
- DIV/REM/DIVU: rs1=0xFFFFFFF7, rs2=0x00000002 → DIV 0xFFFFFFFC, REM 0xFFFFFFFF, DIVU 0x7FFFFFFB.
- Corner cases:
  - DIVU rs1=0x0A050102, rs2=0 → 0xFFFFFFFF.
  - REMU with the same operands → 0x0A050102.
  - DIV rs1=0x80000000, rs2=0xFFFFFFFF → 0x80000000; REM with the same operands → 0x00000000.
  - With MDU_EARLY_OUT_EN, these complete after edge N+1.
- Handshake:
  - Second start with different operands at edge N+10 is ignored; result matches the first op.
  - start during the done cycle is accepted; its done follows 33 cycles later.
- Reset: rst_n low at edge N+15 of a DIV → busy, done, result, rd_out go 0 immediately, no done pulse. After release, a new MUL 3×4 returns 0x0000000C.
